// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage 16-bit pipeline
//   (IF/ID/EX/MEM/WB). It takes register-use information decoded in ID and
//   status from EX/MEM. It produces per-stage stall/flush/redirect controls
//   and runs a halt-drain sequence once HLT leaves ID. A saturating counter
//   of stalled cycles is kept for performance debug.
//
// Parameters
//   DRAIN_CYC  non-frozen cycles after HLT leaves ID before halted asserts
//   CNT_W      width of stall_cnt
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   id_rdEn1/2, id_rdReg1/2  source-register use of the instruction in ID
//   id_hlt                   ID holds HLT
//   ex_memRd                 EX holds a load
//   ex_wrRegEn, ex_wrReg     EX destination register write
//   ex_redirect              EX resolved a taken branch/jump
//   mem_busy                 data memory not ready; the whole pipe holds
//   stall_*                  per-stage hold controls (combinational)
//   flush_ifid, flush_idex   NOP insertion controls (combinational)
//   pc_redirect              PC loads the EX target this cycle (combinational)
//   halted                   pipeline drained after HLT; sticky until reset
//   stall_cnt                cycles with stall_pc=1 outside HALT, saturating
module pipe_hazard_ctrl #(
  parameter int unsigned DRAIN_CYC = 3,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_rdEn1,
  input  logic             id_rdEn2,
  input  logic [3:0]       id_rdReg1,
  input  logic [3:0]       id_rdReg2,
  input  logic             id_hlt,
  input  logic             ex_memRd,
  input  logic             ex_wrRegEn,
  input  logic [3:0]       ex_wrReg,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             pc_redirect,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned DRAIN_W   = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam int unsigned DRAIN_MAX = (DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  // R0 is hard-wired, so it never creates a dependency.
  logic ex_load_dst;
  logic src1_hit;
  logic src2_hit;
  logic load_use;

  assign ex_load_dst = ex_memRd & ex_wrRegEn & (ex_wrReg != 4'd0);
  assign src1_hit    = id_rdEn1 & (id_rdReg1 == ex_wrReg);
  assign src2_hit    = id_rdEn2 & (id_rdReg2 == ex_wrReg);
  assign load_use    = ex_load_dst & (src1_hit | src2_hit);

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and control outputs, resolved in priority order.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    pc_redirect = 1'b0;

    if (!rst) begin
      if (state_q == S_HALT) begin
        // Frozen until reset.
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
      end else if (mem_busy) begin
        // Whole pipe holds; drain progress is suspended too.
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
      end else if (ex_redirect) begin
        // Younger instructions are wrong-path, including any HLT being drained.
        pc_redirect = 1'b1;
        flush_ifid  = 1'b1;
        flush_idex  = 1'b1;
        if (state_q == S_DRAIN) begin
          state_d     = S_RUN;
          drain_cnt_d = '0;
        end
      end else if (load_use) begin
        // Hold the consumer in ID and send one bubble into EX.
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if ((state_q == S_RUN) && id_hlt) begin
        // HLT moves on to EX; nothing behind it is fetched.
        stall_pc    = 1'b1;
        flush_ifid  = 1'b1;
        state_d     = S_DRAIN;
        drain_cnt_d = '0;
      end else if (state_q == S_DRAIN) begin
        stall_pc   = 1'b1;
        flush_ifid = 1'b1;
        if (drain_cnt_q == DRAIN_W'(DRAIN_MAX)) begin
          state_d = S_HALT;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_W'(1);
        end
      end
    end
  end

  // Performance counter: stalled cycles before halt, saturating at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_pc && (state_q != S_HALT) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  assign halted    = (state_q == S_HALT);
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Scoreboard bench: each driven cycle pushes the expected controls from a
//   reference model; the entry is popped and compared on the falling edge.
module tb_pipe_hazard_ctrl;

  localparam int unsigned DRAIN_CYC = 3;
  localparam int unsigned CNT_W     = 4;

  typedef struct {
    logic       rst;
    logic       rdEn1;
    logic       rdEn2;
    logic [3:0] r1;
    logic [3:0] r2;
    logic       hlt;
    logic       memRd;
    logic       wrEn;
    logic [3:0] wr;
    logic       redir;
    logic       busy;
  } stim_t;

  typedef struct {
    logic [7:0]       ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             id_rdEn1, id_rdEn2;
  logic [3:0]       id_rdReg1, id_rdReg2;
  logic             id_hlt;
  logic             ex_memRd, ex_wrRegEn;
  logic [3:0]       ex_wrReg;
  logic             ex_redirect;
  logic             mem_busy;
  logic             stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic             flush_ifid, flush_idex, pc_redirect, halted;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_ctrl #(.DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rdEn1(id_rdEn1), .id_rdEn2(id_rdEn2),
    .id_rdReg1(id_rdReg1), .id_rdReg2(id_rdReg2),
    .id_hlt(id_hlt),
    .ex_memRd(ex_memRd), .ex_wrRegEn(ex_wrRegEn), .ex_wrReg(ex_wrReg),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid),
    .stall_idex(stall_idex), .stall_exmem(stall_exmem),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .pc_redirect(pc_redirect), .halted(halted), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  // Reference model state: 0=RUN 1=DRAIN 2=HALT.
  int   m_state = 0;
  int   m_drain = 0;
  int   m_cnt   = 0;

  // Last observed DUT values, for scenario-level checks.
  logic obs_halted;
  logic [CNT_W-1:0] obs_cnt;
  logic obs_stall_pc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, rdEn1: 1'b0, rdEn2: 1'b0, r1: 4'd0, r2: 4'd0, hlt: 1'b0,
          memRd: 1'b0, wrEn: 1'b0, wr: 4'd0, redir: 1'b0, busy: 1'b0};
    return s;
  endfunction

  // Expected controls: {stall_pc,stall_ifid,stall_idex,stall_exmem,flush_ifid,flush_idex,pc_redirect,halted}
  function automatic logic [7:0] model_ctl(input stim_t s);
    logic lu;
    lu = s.memRd & s.wrEn & (s.wr != 4'd0) &
         ((s.rdEn1 & (s.r1 == s.wr)) | (s.rdEn2 & (s.r2 == s.wr)));
    if (s.rst)             return 8'b0000_0000;
    if (m_state == 2)      return 8'b1111_0001;
    if (s.busy)            return 8'b1111_0000;
    if (s.redir)           return 8'b0000_1110;
    if (lu)                return 8'b1100_0100;
    if (m_state == 0 && s.hlt) return 8'b1000_1000;
    if (m_state == 1)      return 8'b1000_1000;
    return 8'b0000_0000;
  endfunction

  task automatic model_update(input stim_t s, input logic [7:0] ctl);
    if (s.rst) begin
      m_state = 0; m_drain = 0; m_cnt = 0;
      return;
    end
    if (ctl[7] && m_state != 2 && m_cnt != (1 << CNT_W) - 1) m_cnt++;
    // Only the HLT-entry, drain and redirect-cancel rows move the state.
    if (m_state == 2 || s.busy) return;
    if (s.redir) begin
      if (m_state == 1) begin m_state = 0; m_drain = 0; end
    end else if (ctl == 8'b1000_1000) begin
      if (m_state == 0) begin
        m_state = 1; m_drain = 0;
      end else if (m_drain == DRAIN_CYC - 1) begin
        m_state = 2;
      end else begin
        m_drain++;
      end
    end
  endtask

  // One cycle: drive, push expectation, compare at negedge, advance model at posedge.
  task automatic step(input stim_t s);
    exp_t e, g;
    rst = s.rst; id_rdEn1 = s.rdEn1; id_rdEn2 = s.rdEn2;
    id_rdReg1 = s.r1; id_rdReg2 = s.r2; id_hlt = s.hlt;
    ex_memRd = s.memRd; ex_wrRegEn = s.wrEn; ex_wrReg = s.wr;
    ex_redirect = s.redir; mem_busy = s.busy;
    e.ctl = model_ctl(s);
    e.cnt = s.rst ? '0 : CNT_W'(m_cnt);
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL sb_empty got=0 exp=1");
    end else begin
      g = sb_q.pop_front();
      check_eq("ctl", 32'({stall_pc, stall_ifid, stall_idex, stall_exmem,
                           flush_ifid, flush_idex, pc_redirect, halted}), 32'(g.ctl));
      check_eq("cnt", 32'(stall_cnt), 32'(g.cnt));
    end
    obs_halted = halted; obs_cnt = stall_cnt; obs_stall_pc = stall_pc;
    @(posedge clk);
    model_update(s, e.ctl);
    #1;
  endtask

  task automatic do_reset();
    stim_t s;
    s = idle(); s.rst = 1'b1;
    step(s); step(s);
  endtask

  initial begin
    stim_t s;
    int    cyc;
    logic  seen;
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, lu;
    int    cyc;
    logic  seen;
    @(posedge clk); #1;
    // Reset: all outputs 0 even with busy asserted.
    s = idle(); s.rst = 1'b1; s.busy = 1'b1; s.redir = 1'b1;
    step(s);
    do_reset();

    // T1 load-use: LW R3 in EX, ID reads R3 on port 1 -> one bubble.
    lu = idle(); lu.memRd = 1; lu.wrEn = 1; lu.wr = 4'd3; lu.rdEn1 = 1; lu.r1 = 4'd3; lu.r2 = 4'd1;
    step(lu);
    check_eq("t1_stall_pc", 32'(obs_stall_pc), 32'd1);
    step(idle());
    check_eq("t1_next_pc", 32'(obs_stall_pc), 32'd0);
    // Same hazard through port 2.
    s = idle(); s.memRd = 1; s.wrEn = 1; s.wr = 4'd9; s.rdEn2 = 1; s.r2 = 4'd9;
    step(s);

    // T2: R0 destination, non-load producer, and disabled read port -> no stall.
    s = idle(); s.memRd = 1; s.wrEn = 1; s.wr = 4'd0; s.rdEn1 = 1; s.r1 = 4'd0;
    step(s);
    check_eq("t2_r0", 32'(obs_stall_pc), 32'd0);
    s = idle(); s.wrEn = 1; s.wr = 4'd3; s.rdEn2 = 1; s.r2 = 4'd3;
    step(s);
    s = idle(); s.memRd = 1; s.wrEn = 1; s.wr = 4'd5; s.rdEn1 = 0; s.r1 = 4'd5;
    step(s);

    // T3: redirect beats load-use; mem_busy beats both; redirect follows.
    s = lu; s.redir = 1;
    step(s);
    check_eq("t3_stall_pc", 32'(obs_stall_pc), 32'd0);
    s = lu; s.redir = 1; s.busy = 1;
    step(s);
    s = idle(); s.redir = 1;
    step(s);

    // T4: HLT drain with no events -> halted exactly 1+DRAIN_CYC cycles later.
    s = idle(); s.hlt = 1;
    step(s);
    cyc = 0;
    while (!obs_halted && cyc < 20) begin step(idle()); cyc++; end
    check_eq("t4_latency", 32'(cyc), 32'(DRAIN_CYC + 1));
    s = idle(); s.redir = 1; s.busy = 1;
    for (int i = 0; i < 3; i++) step(s);
    check_eq("t4_sticky", 32'(obs_halted), 32'd1);
    do_reset();
    // Two mem_busy cycles inside the drain add two cycles.
    s = idle(); s.hlt = 1;
    step(s);
    step(idle());
    s = idle(); s.busy = 1;
    step(s); step(s);
    cyc = 3;
    while (!obs_halted && cyc < 20) begin step(idle()); cyc++; end
    check_eq("t4_busy_latency", 32'(cyc), 32'(DRAIN_CYC + 3));
    do_reset();

    // T5: redirect on the first drain cycle cancels the halt.
    s = idle(); s.hlt = 1;
    step(s);
    s = idle(); s.redir = 1;
    step(s);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin step(idle()); seen |= obs_halted; end
    check_eq("t5_no_halt", 32'(seen), 32'd0);

    // T6: reset mid-drain aborts; then stall counter saturates.
    do_reset();
    s = idle(); s.hlt = 1;
    step(s);
    step(idle());
    s = idle(); s.rst = 1; s.busy = 1;
    step(s);
    s = idle(); s.busy = 1;
    for (int i = 0; i < 20; i++) step(s);
    step(idle());
    check_eq("t6_sat", 32'(obs_cnt), 32'd15);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      s = idle();
      s.rdEn1 = 1'($urandom_range(0, 1)); s.rdEn2 = 1'($urandom_range(0, 1));
      s.r1 = 4'($urandom_range(0, 3));    s.r2 = 4'($urandom_range(0, 3));
      s.memRd = 1'($urandom_range(0, 1)); s.wrEn = 1'($urandom_range(0, 1));
      s.wr = 4'($urandom_range(0, 3));
      s.redir = ($urandom_range(0, 5) == 0);
      s.busy  = ($urandom_range(0, 5) == 0);
      s.hlt   = ($urandom_range(0, 30) == 0);
      if ($urandom_range(0, 60) == 0) s.rst = 1'b1;
      step(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
